// File: rtl/ram_hs_responder.sv
// Single-beat write/read memory responder with a 2-entry read response queue.
// Tracks written locations and flags reads of never-written words.
module ram_hs_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    written_q;
    logic [DATA_W-1:0]   q_data_q [2];
    logic                q_err_q [2];
    logic [CNT_W-1:0]    wr_cnt_q;
    logic [CNT_W-1:0]    rd_cnt_q;

    logic                pop;
    logic                accept;
    logic                push;
    logic                wr_accept;
    logic [DATA_W-1:0]   rd_data_d;
    logic                rd_err_d;

    // A full queue may still accept when its head is popped on the same edge.
    assign rsp_valid = (state_q != IDLE);
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = !rst && ((state_q != FULL) || pop);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !req_wr;
    assign wr_accept = accept && req_wr;

    assign rd_data_d = mem_q[req_addr];
    assign rd_err_d  = !written_q[req_addr];

    assign rsp_rdata = q_data_q[0];
    assign rsp_err   = q_err_q[0];
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
        end else if (wr_accept) begin
            mem_q[req_addr]     <= req_wdata;
            written_q[req_addr] <= 1'b1;
        end
    end

    // Entry 0 is always the head; entry 1 shifts forward on a pop from FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_data_q[0] <= '0;
            q_data_q[1] <= '0;
            q_err_q[0]  <= 1'b0;
            q_err_q[1]  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            if (wr_accept) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
            if (push) begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (push) begin
                        q_data_q[0] <= rd_data_d;
                        q_err_q[0]  <= rd_err_d;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        q_data_q[0] <= rd_data_d;
                        q_err_q[0]  <= rd_err_d;
                    end else if (push) begin
                        q_data_q[1] <= rd_data_d;
                        q_err_q[1]  <= rd_err_d;
                        state_q     <= FULL;
                    end else if (pop) begin
                        state_q     <= IDLE;
                    end
                end
                FULL: begin
                    if (pop) begin
                        q_data_q[0] <= q_data_q[1];
                        q_err_q[0]  <= q_err_q[1];
                        if (push) begin
                            q_data_q[1] <= rd_data_d;
                            q_err_q[1]  <= rd_err_d;
                        end else begin
                            state_q <= ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_hs_responder.sv
// Directed, table-driven bench for ram_hs_responder with a counter-wrap sequence.
module tb_ram_hs_responder;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [3:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] wr_cnt;
    logic [7:0] rd_cnt;

    int assertCount;
    int failCount;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       wr;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic       rspReady;
        logic       expReady;
        logic       expValid;
        logic [3:0] expRdata;
        logic       expErr;
        logic [7:0] expWrCnt;
        logic [7:0] expRdCnt;
    } vec_t;

    vec_t vecs[$];

    ram_hs_responder #(
        .ADDR_W(4),
        .DATA_W(4),
        .DEPTH (16),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one vector mid-cycle, check req_ready before the edge and the rest after it.
    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = v.rspReady;
        #1;
        checkOutput($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(v.expReady));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'(v.expValid));
        if (v.expValid) begin
            checkOutput($sformatf("v%0d rsp_rdata", idx), 32'(rsp_rdata), 32'(v.expRdata));
            checkOutput($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.expErr));
        end
        checkOutput($sformatf("v%0d wr_cnt", idx), 32'(wr_cnt), 32'(v.expWrCnt));
        checkOutput($sformatf("v%0d rd_cnt", idx), 32'(rd_cnt), 32'(v.expRdCnt));
    endtask

    initial begin
        vec_t w;
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
        req_addr    = 4'h0;
        req_wdata   = 4'h0;
        rsp_ready   = 1'b0;

        // rst valid wr addr wdata rspReady | expReady expValid expRdata expErr expWrCnt expRdCnt
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h3, 4'h8, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd1, 8'd0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 8'd1, 8'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd1, 8'd1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h9, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd1, 8'd2});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h9, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd2, 8'd2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h9, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 8'd2, 8'd3});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 8'd2, 8'd4});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd3, 8'd4});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd4, 8'd4});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h3, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd5, 8'd4});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'd5, 8'd5});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'd5, 8'd6});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 8'd5, 8'd6});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 8'd5, 8'd6});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h5, 4'h4, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 8'd5, 8'd6});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 8'd5, 8'd7});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 8'd5, 8'd7});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd5, 8'd7});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h7, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd6, 8'd7});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 8'd6, 8'd8});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 8'd6, 8'd8});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 8'd6, 8'd9});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd0, 8'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0, 8'd1});

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
        end

        // 256 writes wrap wr_cnt back to 0 while rd_cnt stays put.
        for (int i = 0; i < 256; i++) begin
            w = '{1'b0, 1'b1, 1'b1, 4'(i), 4'(i), 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'(i + 1), 8'd1};
            applyStimulus(100 + i, w);
        end
        w = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 8'd0, 8'd2};
        applyStimulus(400, w);
        w = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0, 8'd2};
        applyStimulus(401, w);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ram_hs_responder.md
Name: ram_hs_responder

Overview:
Synthesizable memory responder that sits at the target end of the write/read access stream. An access sequencer or a testbench state machine issues single-beat write and read requests. The block holds a DEPTH x DATA_W storage array, accepts one request per cycle through a valid/ready handshake, and returns read data through a 2-entry response queue that absorbs backpressure. It also tracks which locations have been written since reset and flags reads of unwritten locations.

Parameters:
ADDR_W, 4, request address width
DATA_W, 4, data width
DEPTH, 16, number of words (must equal 2**ADDR_W)
CNT_W, 8, width of access counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept request this cycle
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  read response present at queue head
rsp_ready  in  1  consumer takes response this cycle
rsp_rdata  out  DATA_W  read data at queue head
rsp_err  out  1  head response read a never-written location
wr_cnt  out  CNT_W  accepted writes since reset, wraps
rd_cnt  out  CNT_W  accepted reads since reset, wraps

Behaviour:
- Accept: request accepted on a rising edge where req_valid && req_ready. The request is sampled only at that edge.
- req_ready is combinational: req_ready = (q_count != 2) || (rsp_valid && rsp_ready). This allows a full queue to accept when a pop happens in the same cycle.
- Write accept: mem[req_addr] <= req_wdata and written[req_addr] <= 1 at the accepting edge. No response is generated. wr_cnt increments.
- Read accept: at the accepting edge, push {mem[req_addr], ~written[req_addr]} into the response queue. rd_cnt increments.
  - Read data reflects all writes accepted on earlier edges.
  - A read accepted on the edge immediately after a write to the same address returns the new data.
- Latency: a read accepted at edge N gives rsp_valid=1 from edge N (visible the cycle after acceptance) when the queue was empty. Otherwise it waits behind older entries, in order.
- Response queue: 2 entries, FIFO order, q_count in 0..2.
  - rsp_valid = (q_count != 0).
  - rsp_rdata and rsp_err come from the head entry and hold stable while rsp_valid && !rsp_ready.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop on the same edge leave q_count unchanged and preserve order.
- Full: q_count==2 with no pop forces req_ready=0. A write is also blocked in this state, because req_ready does not depend on req_wr.
- Empty: rsp_valid=0, and rsp_ready is ignored.
- Counters: CNT_W-bit, wrap from all-ones to 0.
- Reset (rst=1 at an edge), applied mid-operation as well:
  - q_count=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - wr_cnt=0, rd_cnt=0.
  - All written bits = 0 and all mem words = 0.
  - A request presented during a reset cycle is not accepted.
  - req_ready while rst=1 is don't-care for the initiator. The block drives it 0.
- req_addr is always in range (DEPTH = 2**ADDR_W), so no out-of-range handling is needed.
- State summary per cycle: IDLE (q_count=0), ONE (q_count=1), FULL (q_count=2). Transitions:
  - +1 on push without pop.
  - -1 on pop without push.
  - Hold on both or neither.

Test Plan:
- Reset then write/read alternation: rst for 1 cycle; write addr 3 data 4'b1000, then read addr 3 with rsp_ready=1 -> rsp_valid one cycle after read accept, rsp_rdata=4'b1000, rsp_err=0, wr_cnt=1, rd_cnt=1.
- Unwritten read: after reset, read addr 9 -> rsp_rdata=0, rsp_err=1. Then write addr 9 data 4'h5 and read addr 9 -> rsp_rdata=4'h5, rsp_err=0.
- Backpressure/full: rsp_ready=0, issue reads of addr 1, 2, 3 (pre-written 4'h1, 4'h2, 4'h3) -> first two accepted, req_ready=0 with third held, rsp_rdata stays 4'h1. Raise rsp_ready -> third accepted in the pop cycle; responses 4'h1, 4'h2, 4'h3 in order.
- Back-to-back write-then-read same address: write addr 7 data 4'hA at edge N, read addr 7 at edge N+1 -> rsp_rdata=4'hA.
- Reset mid-operation: queue holds 2 responses, rst asserted 1 cycle -> rsp_valid=0, counters 0. Read addr 3 -> rsp_rdata=0, rsp_err=1.
- Counter wrap: 256 accepted writes with CNT_W=8 -> wr_cnt returns to 0, rd_cnt unchanged.
